// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register offsets, bit positions and
// the bus-handshake state encoding.
package apb_timer_pkg;

    localparam logic [4:0] TCR  = 5'h00;
    localparam logic [4:0] TCNT = 5'h04;
    localparam logic [4:0] PSC  = 5'h08;
    localparam logic [4:0] ARR  = 5'h0C;
    localparam logic [4:0] SR   = 5'h10;

    localparam int TCR_EN      = 0;
    localparam int TCR_ONESHOT = 1;
    localparam int TCR_UIE     = 2;
    localparam int TCR_CLR     = 3;

    localparam int SR_UIF = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } apb_state_t;

    // The block decodes word addresses only; byte lanes are ignored.
    function automatic logic [4:0] reg_offset(input logic [2:0] word);
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/apb_timer_core.sv
// Prescaler plus auto-reload up-counter. Produces a one-cycle update pulse on
// every reload and a stop request when running in one-shot mode.
module apb_timer_core
    import apb_timer_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    input  logic [CNT_W-1:0] arr,
    input  logic             oneshot,
    output logic [CNT_W-1:0] tcnt,
    output logic             update,
    output logic             oneshot_stop
);

    logic [PSC_W-1:0] pcnt;
    logic             tick;
    logic             wrap;

    assign tick = en && (pcnt == psc);
    assign wrap = (tcnt == arr);

    // A clear committed on the same edge suppresses the reload event.
    assign update       = tick && wrap && !clr;
    assign oneshot_stop = update && oneshot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            tcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
            tcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + PSC_W'(1);
            if (tick) begin
                tcnt <= wrap ? '0 : tcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/apb_timer_periph.sv
// APB slave wrapper for the timer: one-wait-state handshake FSM, control and
// status registers, and the level interrupt output.
module apb_timer_periph
    import apb_timer_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PSC_W = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq
);

    apb_state_t       state;
    apb_state_t       state_nxt;
    logic             commit;

    logic             en;
    logic             oneshot;
    logic             uie;
    logic             uif;
    logic [PSC_W-1:0] psc;
    logic [CNT_W-1:0] arr;
    logic [CNT_W-1:0] tcnt;
    logic             update;
    logic             oneshot_stop;

    logic [4:0]       reg_off;
    logic             wr;
    logic             rd;
    logic             wr_tcr;
    logic             wr_psc;
    logic             wr_arr;
    logic             wr_sr;
    logic             clr;
    logic [31:0]      rdata;
    logic             unused_bits;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // WAIT swallows an access phase the master holds past PREADY, so a held
    // PSEL/PENABLE never commits the same transfer twice.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && PENABLE) begin
                    commit    = 1'b1;
                    state_nxt = READY;
                end
            end
            READY: begin
                state_nxt = (PSEL && PENABLE) ? WAIT : IDLE;
            end
            WAIT: begin
                if (!(PSEL && PENABLE)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign PREADY = (state == READY);

    assign reg_off = reg_offset(PADDR[4:2]);
    assign wr      = commit && PWRITE;
    assign rd      = commit && !PWRITE;
    assign wr_tcr  = wr && (reg_off == TCR);
    assign wr_psc  = wr && (reg_off == PSC);
    assign wr_arr  = wr && (reg_off == ARR);
    assign wr_sr   = wr && (reg_off == SR);
    assign clr     = wr_tcr && PWDATA[TCR_CLR];

    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA};

    always_comb begin
        rdata = '0;
        case (reg_off)
            TCR: begin
                rdata[TCR_EN]      = en;
                rdata[TCR_ONESHOT] = oneshot;
                rdata[TCR_UIE]     = uie;
            end
            TCNT:    rdata[CNT_W-1:0] = tcnt;
            PSC:     rdata[PSC_W-1:0] = psc;
            ARR:     rdata[CNT_W-1:0] = arr;
            SR:      rdata[SR_UIF]    = uif;
            default: rdata = '0;
        endcase
    end

    // Software writes to TCR beat the one-shot auto-stop; a hardware update
    // beats a software clear of UIF.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en      <= 1'b0;
            oneshot <= 1'b0;
            uie     <= 1'b0;
            uif     <= 1'b0;
            psc     <= '0;
            arr     <= '0;
            PRDATA  <= '0;
        end else begin
            if (wr_tcr) begin
                en      <= PWDATA[TCR_EN];
                oneshot <= PWDATA[TCR_ONESHOT];
                uie     <= PWDATA[TCR_UIE];
            end else if (oneshot_stop) begin
                en <= 1'b0;
            end
            if (wr_psc) begin
                psc <= PWDATA[PSC_W-1:0];
            end
            if (wr_arr) begin
                arr <= PWDATA[CNT_W-1:0];
            end
            if (update) begin
                uif <= 1'b1;
            end else if (wr_sr && PWDATA[SR_UIF]) begin
                uif <= 1'b0;
            end
            if (rd) begin
                PRDATA <= rdata;
            end
        end
    end

    assign irq = uif && uie;

    apb_timer_core #(
        .CNT_W(CNT_W),
        .PSC_W(PSC_W)
    ) u_core (
        .clk         (PCLK),
        .rst         (PRESET),
        .en          (en),
        .clr         (clr),
        .psc         (psc),
        .arr         (arr),
        .oneshot     (oneshot),
        .tcnt        (tcnt),
        .update      (update),
        .oneshot_stop(oneshot_stop)
    );

endmodule

// File: tb/tb_apb_timer_periph.sv
// Directed testbench for apb_timer_periph: handshake, prescaled counting,
// one-shot, UIF set/clear race, CLR override and asynchronous reset.
module tb_apb_timer_periph;

    localparam logic [31:0] A_TCR  = 32'h00;
    localparam logic [31:0] A_TCNT = 32'h04;
    localparam logic [31:0] A_PSC  = 32'h08;
    localparam logic [31:0] A_ARR  = 32'h0C;
    localparam logic [31:0] A_SR   = 32'h10;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PSEL = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    apb_timer_periph #(
        .CNT_W(16),
        .PSC_W(16)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PWRITE (PWRITE),
        .PENABLE(PENABLE),
        .PSEL   (PSEL),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .irq    (irq)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 300000", $time);
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the PREADY cycle.
    task automatic apb_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic rdy_acc,
                              output logic irq_acc, output logic irq_rdy, output int waits);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        rdy_acc = PREADY;
        irq_acc = irq;
        waits = 0;
        do begin
            @(posedge PCLK); #1;
            waits++;
        end while (!PREADY && waits < 16);
        if (!PREADY) begin
            n_err++;
            $display("FAIL apb_timeout addr=%h: PREADY=0 after %0d cycles, required 1", addr, waits);
        end
        rdata = PRDATA;
        irq_rdy = irq;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] r; logic a, b, c; int w;
        apb_access(1'b1, addr, data, r, a, b, c, w);
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        logic a, b, c; int w;
        apb_access(1'b0, addr, 32'h0, data, a, b, c, w);
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic ra, ia, ir; int w;
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        n_vec++; if (PREADY !== 1'b0) begin n_err++; $display("FAIL rst_pready: got %b required 0", PREADY); end
        n_vec++; if (PRDATA !== 32'h0) begin n_err++; $display("FAIL rst_prdata: got %h required 0", PRDATA); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b required 0", irq); end
        PRESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            apb_access(1'b0, 32'(i * 4), 32'h0, rd, ra, ia, ir, w);
            n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_read off=%0h: got %h required 0", i * 4, rd); end
            n_vec++; if (ra !== 1'b0 || w != 1) begin n_err++; $display("FAIL rst_ready_lat off=%0h: acc PREADY=%b wait=%0d required 0/1", i * 4, ra, w); end
            n_vec++; if (PREADY !== 1'b0) begin n_err++; $display("FAIL rst_ready_width off=%0h: got %b required 0", i * 4, PREADY); end
            n_vec++; if (ir !== 1'b0) begin n_err++; $display("FAIL rst_irq_read off=%0h: got %b required 0", i * 4, ir); end
        end
    endtask

    task automatic test_handshake();
        logic [31:0] rd; logic exp;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_ARR; PWDATA = 32'h5;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            exp = (c == 2);
            n_vec++; if (PREADY !== exp) begin n_err++; $display("FAIL hs_pready cycle %0d: got %b required %b", c, PREADY, exp); end
            @(posedge PCLK); #1;
        end
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb_read(A_ARR, rd);
        n_vec++; if (rd !== 32'h5) begin n_err++; $display("FAIL hs_readback: got %h required 00000005", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        apb_write(A_PSC, 32'hFFFF_1234);
        apb_read(A_PSC, rd);
        n_vec++; if (rd !== 32'h0000_1234) begin n_err++; $display("FAIL b2b_psc: got %h required 00001234", rd); end
        apb_read(A_ARR, rd);
        n_vec++; if (rd !== 32'h5) begin n_err++; $display("FAIL b2b_arr: got %h required 00000005", rd); end
        apb_write(A_TCNT, 32'h77);
        apb_read(A_TCNT, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL b2b_tcnt_ro: got %h required 0", rd); end
        apb_write(32'h14, 32'hFFFF_FFFF);
        apb_read(32'h14, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL b2b_unmapped: got %h required 0", rd); end
        apb_write(A_TCR, 32'hE);
        apb_read(A_TCR, rd);
        n_vec++; if (rd !== 32'h6) begin n_err++; $display("FAIL b2b_tcr_clr_reads0: got %h required 00000006", rd); end
        apb_write(A_TCR, 32'h0);
    endtask

    task automatic test_freerun();
        logic [31:0] rd; logic ra, ia, ir; int w;
        apb_write(A_PSC, 32'd2);
        apb_write(A_ARR, 32'd3);
        apb_write(A_TCR, 32'h5);
        for (int i = 0; i < 3; i++) begin
            apb_read(A_TCNT, rd);
            n_vec++; if (rd !== 32'(i)) begin n_err++; $display("FAIL fr_tcnt step %0d: got %h required %h", i, rd, 32'(i)); end
        end
        apb_access(1'b0, A_TCNT, 32'h0, rd, ra, ia, ir, w);
        n_vec++; if (rd !== 32'd3) begin n_err++; $display("FAIL fr_tcnt step 3: got %h required 00000003", rd); end
        n_vec++; if (ia !== 1'b0) begin n_err++; $display("FAIL fr_irq_before_wrap: got %b required 0", ia); end
        n_vec++; if (ir !== 1'b1) begin n_err++; $display("FAIL fr_irq_at_wrap: got %b required 1", ir); end
        apb_read(A_TCNT, rd);
        n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL fr_tcnt_wrapped: got %h required 0", rd); end
        apb_read(A_SR, rd);
        n_vec++; if (rd !== 32'd1) begin n_err++; $display("FAIL fr_uif: got %h required 00000001", rd); end
        apb_write(A_TCR, 32'h8);
        apb_write(A_SR, 32'h1);
        apb_read(A_SR, rd);
        n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL fr_uif_w1c: got %h required 0", rd); end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        apb_write(A_PSC, 32'd0);
        apb_write(A_ARR, 32'd4);
        apb_write(A_TCR, 32'h3);
        repeat (2) @(posedge PCLK);
        #1;
        apb_read(A_TCNT, rd);
        n_vec++; if (rd !== 32'd4) begin n_err++; $display("FAIL os_tcnt_top: got %h required 00000004", rd); end
        apb_read(A_TCNT, rd);
        n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL os_tcnt_after: got %h required 0", rd); end
        apb_read(A_TCR, rd);
        n_vec++; if (rd !== 32'h2) begin n_err++; $display("FAIL os_en_cleared: got %h required 00000002", rd); end
        apb_read(A_SR, rd);
        n_vec++; if (rd !== 32'd1) begin n_err++; $display("FAIL os_uif: got %h required 00000001", rd); end
        repeat (5) @(posedge PCLK);
        #1;
        apb_read(A_TCNT, rd);
        n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL os_tcnt_stopped: got %h required 0", rd); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL os_irq_masked: got %b required 0", irq); end
        apb_write(A_SR, 32'h1);
    endtask

    task automatic test_uif_race();
        logic [31:0] rd; logic ra, ia, ir; int w;
        apb_write(A_ARR, 32'd5);
        apb_write(A_TCR, 32'h5);
        repeat (3) @(posedge PCLK);
        #1;
        apb_write(A_SR, 32'h1);
        apb_write(A_TCR, 32'h4);
        apb_access(1'b0, A_SR, 32'h0, rd, ra, ia, ir, w);
        n_vec++; if (rd !== 32'd1) begin n_err++; $display("FAIL race_uif_set_wins: got %h required 00000001", rd); end
        n_vec++; if (ir !== 1'b1) begin n_err++; $display("FAIL race_irq: got %b required 1", ir); end
        apb_read(A_TCNT, rd);
        n_vec++; if (rd !== 32'd3) begin n_err++; $display("FAIL race_tcnt_frozen: got %h required 00000003", rd); end
        repeat (5) @(posedge PCLK);
        #1;
        apb_read(A_TCNT, rd);
        n_vec++; if (rd !== 32'd3) begin n_err++; $display("FAIL race_tcnt_still: got %h required 00000003", rd); end
        apb_write(A_SR, 32'h1);
        apb_access(1'b0, A_SR, 32'h0, rd, ra, ia, ir, w);
        n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL race_uif_cleared: got %h required 0", rd); end
        n_vec++; if (ir !== 1'b0) begin n_err++; $display("FAIL race_irq_cleared: got %b required 0", ir); end
    endtask

    task automatic test_clr();
        logic [31:0] rd;
        apb_write(A_TCR, 32'h8);
        apb_write(A_ARR, 32'd3);
        apb_write(A_TCR, 32'h1);
        @(posedge PCLK); #1;
        apb_write(A_TCR, 32'h9);
        apb_read(A_SR, rd);
        n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL clr_no_update: got %h required 0", rd); end
        apb_read(A_TCNT, rd);
        n_vec++; if (rd !== 32'd1) begin n_err++; $display("FAIL clr_resume: got %h required 00000001", rd); end
        apb_write(A_TCR, 32'h0);
        apb_read(A_SR, rd);
        n_vec++; if (rd !== 32'd1) begin n_err++; $display("FAIL clr_later_update: got %h required 00000001", rd); end
        apb_write(A_SR, 32'h1);
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; logic [31:0] offs [5];
        offs[0] = A_TCR; offs[1] = A_TCNT; offs[2] = A_PSC; offs[3] = A_ARR; offs[4] = A_SR;
        apb_write(A_TCR, 32'h5);
        repeat (6) @(posedge PCLK);
        #1;
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL ar_irq_pre: got %b required 1", irq); end
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_ARR;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        n_vec++; if (PREADY !== 1'b1) begin n_err++; $display("FAIL ar_pready_pre: got %b required 1", PREADY); end
        n_vec++; if (PRDATA !== 32'd3) begin n_err++; $display("FAIL ar_prdata_pre: got %h required 00000003", PRDATA); end
        #2;
        PRESET = 1'b1;
        #1;
        n_vec++; if (PREADY !== 1'b0) begin n_err++; $display("FAIL ar_pready_async: got %b required 0", PREADY); end
        n_vec++; if (PRDATA !== 32'd0) begin n_err++; $display("FAIL ar_prdata_async: got %h required 0", PRDATA); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL ar_irq_async: got %b required 0", irq); end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apb_read(offs[i], rd);
            n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL ar_reg off=%h: got %h required 0", offs[i], rd); end
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_back_to_back();
        test_freerun();
        test_oneshot();
        test_uif_race();
        test_clr();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
